// File: rtl/mand_pixel_scheduler_pkg.sv
// Shared definitions for the Mandelbrot pixel scheduler: fixed-point widths, iteration
// encoding, FSM states and the iteration-to-colour palette helper.
package mand_pixel_scheduler_pkg;

    localparam int FIX_W    = 27;
    localparam int FIX_FRAC = 23;
    localparam int ITER_W   = 32;

    localparam logic [ITER_W-1:0] ITER_CONVERGED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SOLVE = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    // Converged points map to black, everything else to an RGB332 ramp on the low iteration bits.
    function automatic logic [7:0] iter_to_color(input logic [ITER_W-1:0] iter);
        if (iter == ITER_CONVERGED) begin
            return 8'h00;
        end else begin
            return {iter[4:0], 3'b111};
        end
    endfunction

endpackage

// File: rtl/mand_pixel_scheduler_if.sv
// Pixel result stream from the scheduler to the frame-buffer writer (valid/ready).
interface mand_pixel_scheduler_if #(
    parameter int X_BITS = 10,
    parameter int Y_BITS = 9
);
    import mand_pixel_scheduler_pkg::*;

    logic              pix_valid;
    logic              pix_ready;
    logic [X_BITS-1:0] pix_x;
    logic [Y_BITS-1:0] pix_y;
    logic [ITER_W-1:0] pix_iter;
    logic [7:0]        pix_color;

    modport master (output pix_valid, pix_x, pix_y, pix_iter, pix_color, input pix_ready);
    modport slave  (input pix_valid, pix_x, pix_y, pix_iter, pix_color, output pix_ready);

endinterface

// File: rtl/mand_pixel_scheduler_color_map.sv
// Combinational iteration-count to palette-index mapping (used when MAND_SCHED_COLOR_EN is defined).
module mand_color_map
    import mand_pixel_scheduler_pkg::*;
(
    input  logic [ITER_W-1:0] iter,
    output logic [7:0]        color
);

    assign color = iter_to_color(iter);

endmodule

// File: rtl/mand_pixel_scheduler.sv
// Frame raster scheduler around one mand_solver: steps c per pixel and streams (x, y, iter).
// Optional MAND_SCHED_COLOR_EN adds a registered palette index on pix_color.
module mand_pixel_scheduler
    import mand_pixel_scheduler_pkg::*;
#(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int X_BITS = 10,
    parameter int Y_BITS = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FIX_W-1:0]      re_min,
    input  logic [FIX_W-1:0]      im_max,
    input  logic [FIX_W-1:0]      step,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  solver_reset,
    output logic [FIX_W-1:0]      c_re,
    output logic [FIX_W-1:0]      c_im,
    input  logic                  solver_ready,
    input  logic [ITER_W-1:0]     solver_iter,
    mand_pixel_scheduler_if.master pix
);

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(H_RES - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_RES - 1);

    state_t            state_r;
    logic              busy_r;
    logic              frame_done_r;
    logic              solver_reset_r;
    logic [FIX_W-1:0]  c_re_r;
    logic [FIX_W-1:0]  c_im_r;
    logic [FIX_W-1:0]  re_min_r;
    logic [FIX_W-1:0]  step_r;
    logic [X_BITS-1:0] x_r;
    logic [Y_BITS-1:0] y_r;
    logic              pix_valid_r;
    logic [X_BITS-1:0] pix_x_r;
    logic [Y_BITS-1:0] pix_y_r;
    logic [ITER_W-1:0] pix_iter_r;

    // Frame FSM: raster position, incremental c stepping, solver sequencing and output stream.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            busy_r         <= 1'b0;
            frame_done_r   <= 1'b0;
            solver_reset_r <= 1'b1;
            c_re_r         <= {FIX_W{1'b0}};
            c_im_r         <= {FIX_W{1'b0}};
            re_min_r       <= {FIX_W{1'b0}};
            step_r         <= {FIX_W{1'b0}};
            x_r            <= {X_BITS{1'b0}};
            y_r            <= {Y_BITS{1'b0}};
            pix_valid_r    <= 1'b0;
            pix_x_r        <= {X_BITS{1'b0}};
            pix_y_r        <= {Y_BITS{1'b0}};
            pix_iter_r     <= {ITER_W{1'b0}};
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    solver_reset_r <= 1'b1;
                    if (start) begin
                        re_min_r <= re_min;
                        step_r   <= step;
                        c_re_r   <= re_min;
                        c_im_r   <= im_max;
                        x_r      <= {X_BITS{1'b0}};
                        y_r      <= {Y_BITS{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= ST_LOAD;
                    end
                end
                // One cycle with reset held and c stable lets the solver load z = c.
                ST_LOAD: begin
                    solver_reset_r <= 1'b0;
                    state_r        <= ST_SOLVE;
                end
                ST_SOLVE: begin
                    if (solver_ready) begin
                        pix_iter_r     <= solver_iter;
                        pix_x_r        <= x_r;
                        pix_y_r        <= y_r;
                        pix_valid_r    <= 1'b1;
                        solver_reset_r <= 1'b1;
                        state_r        <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (pix_valid_r && pix.pix_ready) begin
                        pix_valid_r <= 1'b0;
                        if (x_r != X_LAST) begin
                            x_r     <= x_r + X_BITS'(1);
                            c_re_r  <= c_re_r + step_r;
                            state_r <= ST_LOAD;
                        end else begin
                            x_r    <= {X_BITS{1'b0}};
                            c_re_r <= re_min_r;
                            if (y_r == Y_LAST) begin
                                frame_done_r <= 1'b1;
                                busy_r       <= 1'b0;
                                state_r      <= ST_IDLE;
                            end else begin
                                y_r     <= y_r + Y_BITS'(1);
                                c_im_r  <= c_im_r - step_r;
                                state_r <= ST_LOAD;
                            end
                        end
                    end
                end
                default: begin
                    solver_reset_r <= 1'b1;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign frame_done    = frame_done_r;
    assign solver_reset  = solver_reset_r;
    assign c_re          = c_re_r;
    assign c_im          = c_im_r;
    assign pix.pix_valid = pix_valid_r;
    assign pix.pix_x     = pix_x_r;
    assign pix.pix_y     = pix_y_r;
    assign pix.pix_iter  = pix_iter_r;

`ifdef MAND_SCHED_COLOR_EN
    logic [7:0] color_s;
    logic [7:0] pix_color_r;

    mand_color_map u_color_map (
        .iter  (solver_iter),
        .color (color_s)
    );

    // Palette index is captured alongside pix_iter so both stay aligned on the stream.
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_color_r <= 8'h00;
        end else if (state_r == ST_SOLVE && solver_ready) begin
            pix_color_r <= color_s;
        end else begin
            pix_color_r <= pix_color_r;
        end
    end

    assign pix.pix_color = pix_color_r;
`else
    assign pix.pix_color = 8'h00;
`endif

endmodule

// File: tb/tb_mand_pixel_scheduler.sv
// Self-checking bench for mand_pixel_scheduler (4x3 frame) with a behavioural solver stand-in.
module tb_mand_pixel_scheduler;
    import mand_pixel_scheduler_pkg::*;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int XB = 2;
    localparam int YB = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [26:0] re_min_in = 27'd0;
    logic [26:0] im_max_in = 27'd0;
    logic [26:0] step_in   = 27'd0;
    logic        busy, frame_done, solver_reset;
    logic [26:0] c_re, c_im;
    logic        s_ready = 1'b0;
    logic [31:0] s_iter  = 32'd0;
    int          s_cnt = 0;
    int          s_lat = 0;
    logic [26:0] s_re = 27'd0;
    logic [26:0] s_im = 27'd0;
    int          fd_count = 0;
    int          total = 0;
    int          bad = 0;

    mand_pixel_scheduler_if #(.X_BITS(XB), .Y_BITS(YB)) pix_if ();

    mand_pixel_scheduler #(.H_RES(H), .V_RES(V), .X_BITS(XB), .Y_BITS(YB)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .re_min       (re_min_in),
        .im_max       (im_max_in),
        .step         (step_in),
        .busy         (busy),
        .frame_done   (frame_done),
        .solver_reset (solver_reset),
        .c_re         (c_re),
        .c_im         (c_im),
        .solver_ready (s_ready),
        .solver_iter  (s_iter),
        .pix          (pix_if)
    );

    always #5 clock = ~clock;

    // Stand-in solver result: origin converges, anything else escapes after a count derived from c.
    function automatic logic [31:0] model_iter(input logic [26:0] re, input logic [26:0] im);
        if (re == 27'd0 && im == 27'd0) return 32'hFFFF_FFFF;
        return 32'(1 + ((int'(re[26:20]) + int'(im[26:20])) & 15));
    endfunction

    function automatic logic [7:0] model_color(input logic [31:0] it);
`ifdef MAND_SCHED_COLOR_EN
        if (it == 32'hFFFF_FFFF) return 8'h00;
        return {it[4:0], 3'b111};
`else
        return 8'h00;
`endif
    endfunction

    // Solver stand-in: loads c while held in reset, reports after a random number of cycles.
    always @(posedge clock) begin
        if (solver_reset) begin
            s_ready <= 1'b0;
            s_cnt   <= 0;
            s_lat   <= int'($urandom_range(0, 4));
            s_re    <= c_re;
            s_im    <= c_im;
        end else if (!s_ready) begin
            if (s_cnt >= s_lat) begin
                s_ready <= 1'b1;
                s_iter  <= model_iter(s_re, s_im);
            end else begin
                s_cnt <= s_cnt + 1;
            end
        end
    end

    always @(posedge clock) begin
        if (frame_done === 1'b1) fd_count <= fd_count + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input logic [26:0] re0, input logic [26:0] im0, input logic [26:0] st,
                             input int abort_at, input int chg_at, input int stall_at);
        int fd0;
        int n;
        int k;
        int px;
        int py;
        logic [26:0] exp_re;
        logic [26:0] exp_im;
        logic [31:0] exp_it;
        fd0 = fd_count;
        @(negedge clock);
        re_min_in = re0;
        im_max_in = im0;
        step_in   = st;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int idx = 0; idx < H * V; idx++) begin
            px = idx % H;
            py = idx / H;
            exp_re = re0 + 27'(px) * st;
            exp_im = im0 - 27'(py) * st;
            exp_it = model_iter(exp_re, exp_im);
            if (idx == chg_at) begin
                re_min_in = 27'($urandom);
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
            end
            if (idx == abort_at) begin
                n = 0;
                while (solver_reset !== 1'b0 && n < 100) begin
                    @(negedge clock);
                    n++;
                end
                chk("solve_reached", 64'(n < 100), 64'd1);
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                chk("abort_valid", 64'(pix_if.pix_valid), 64'd0);
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_sreset", 64'(solver_reset), 64'd1);
                chk("abort_c_re", 64'(c_re), 64'd0);
                repeat (10) @(negedge clock);
                chk("abort_no_done", 64'(fd_count), 64'(fd0));
                return;
            end
            n = 0;
            while (pix_if.pix_valid !== 1'b1 && n < 200) begin
                @(negedge clock);
                n++;
            end
            chk("valid_timeout", 64'(n < 200), 64'd1);
            chk("pix_x", 64'(pix_if.pix_x), 64'(px));
            chk("pix_y", 64'(pix_if.pix_y), 64'(py));
            chk("pix_iter", 64'(pix_if.pix_iter), 64'(exp_it));
            chk("pix_color", 64'(pix_if.pix_color), 64'(model_color(exp_it)));
            chk("c_re", 64'(c_re), 64'(exp_re));
            chk("c_im", 64'(c_im), 64'(exp_im));
            k = (idx == stall_at) ? 20 : int'($urandom_range(0, 3));
            for (int s = 0; s < k; s++) begin
                @(negedge clock);
                chk("stall_valid", 64'(pix_if.pix_valid), 64'd1);
                chk("stall_sreset", 64'(solver_reset), 64'd1);
                chk("stall_iter", 64'(pix_if.pix_iter), 64'(exp_it));
                chk("stall_xy", 64'({pix_if.pix_x, pix_if.pix_y}), 64'({2'(px), 2'(py)}));
            end
            pix_if.pix_ready = 1'b1;
            @(negedge clock);
            pix_if.pix_ready = 1'b0;
            chk("valid_drop", 64'(pix_if.pix_valid), 64'd0);
            chk("frame_done", 64'(frame_done), 64'(idx == H * V - 1));
            chk("busy_in_frame", 64'(busy), 64'(idx != H * V - 1));
        end
        @(negedge clock);
        chk("one_done_pulse", 64'(fd_count), 64'(fd0 + 1));
        chk("idle_sreset", 64'(solver_reset), 64'd1);
    endtask

    initial begin
        pix_if.pix_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_sreset", 64'(solver_reset), 64'd1);
        chk("rst_c", 64'({c_re, c_im}), 64'd0);
        chk("rst_valid", 64'(pix_if.pix_valid), 64'd0);
        chk("rst_pix", 64'({pix_if.pix_x, pix_if.pix_y, pix_if.pix_iter, pix_if.pix_color}), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        // -2.0 + 1.0i origin, pitch 0.5, long stall on pixel 2
        run_frame(27'h7000000, 27'h0800000, 27'h0400000, -1, -1, 2);
        // origin lands on (2,1); start and re_min disturbed mid-frame
        run_frame(27'h7800000, 27'h0400000, 27'h0400000, -1, 4, -1);
        // first pixel escapes with count 3; reset during SOLVE of pixel 5
        run_frame(27'h0200000, 27'h0000000, 27'($urandom), 5, -1, -1);
        run_frame(27'($urandom), 27'($urandom), 27'($urandom), -1, -1, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
